// File: rtl/sparse_pkg.sv
// Shared constants and element-slicing helper for the zero-skipping dot-product engine.
package sparse_pkg;
  localparam int N_LANES = 16;
  localparam int DATA_W  = 8;
  localparam int PROD_W  = 16;
  localparam int OUT_W   = 20;

  function automatic logic [DATA_W-1:0] lane(input logic [N_LANES*DATA_W-1:0] vec,
                                             input int i);
    return vec[i*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/sparse_lane.sv
// One lane: zero-detect, operand gating and a registered 8x8 unsigned product.
module sparse_lane
  import sparse_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              act,
  output logic [PROD_W-1:0] prod
);
  logic [DATA_W-1:0] a_g;
  logic [DATA_W-1:0] b_g;

  // Idle lanes feed zeros so the multiplier inputs stay quiet.
  assign act = (a != '0) && (b != '0);
  assign a_g = act ? a : '0;
  assign b_g = act ? b : '0;

  always_ff @(posedge clk) begin
    if (rst) prod <= '0;
    else     prod <= PROD_W'(a_g) * PROD_W'(b_g);
  end
endmodule

// File: rtl/sparse.sv
// Two-stage pipelined dot product: 16 gated lane products, then a 4-level adder tree into out_Final.
module sparse
  import sparse_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_LANES*DATA_W-1:0]   Vector_A,
  input  logic [N_LANES*DATA_W-1:0]   Vector_B,
  output logic [OUT_W-1:0]            out_Final
);
  logic [N_LANES-1:0] act;
  logic [PROD_W-1:0]  prod [N_LANES];
  logic [PROD_W:0]    sum1 [8];
  logic [PROD_W+1:0]  sum2 [4];
  logic [PROD_W+2:0]  sum3 [2];
  logic [OUT_W-1:0]   sum4;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    sparse_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .a    (lane(Vector_A, i)),
      .b    (lane(Vector_B, i)),
      .act  (act[i]),
      .prod (prod[i])
    );
  end

  // Balanced tree, each level one bit wider than the last, so no sum can overflow.
  for (genvar j = 0; j < 8; j++) begin : g_l1
    assign sum1[j] = {1'b0, prod[2*j]} + {1'b0, prod[2*j+1]};
  end
  for (genvar j = 0; j < 4; j++) begin : g_l2
    assign sum2[j] = {1'b0, sum1[2*j]} + {1'b0, sum1[2*j+1]};
  end
  for (genvar j = 0; j < 2; j++) begin : g_l3
    assign sum3[j] = {1'b0, sum2[2*j]} + {1'b0, sum2[2*j+1]};
  end
  assign sum4 = {1'b0, sum3[0]} + {1'b0, sum3[1]};

  always_ff @(posedge clk) begin
    if (rst) out_Final <= '0;
    else     out_Final <= sum4;
  end
endmodule

// File: tb/tb_sparse.sv
// Bench for sparse: directed spec cases then random sparse vectors against a dot-product model.
module tb_sparse;
  logic         clk;
  logic         rst;
  logic [127:0] Vector_A;
  logic [127:0] Vector_B;
  logic [19:0]  out_Final;

  int vectors;
  int miscompares;

  // Model state: sum captured at the last edge and the value out_Final should hold.
  logic [19:0] mdl_pipe;
  logic [19:0] mdl_out;

  logic [127:0] ones_v;
  logic [127:0] max_v;
  logic [127:0] zero_v;
  logic [127:0] part_a;
  logic [127:0] twos_v;

  sparse dut (
    .clk       (clk),
    .rst       (rst),
    .Vector_A  (Vector_A),
    .Vector_B  (Vector_B),
    .out_Final (out_Final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] dot(input logic [127:0] a, input logic [127:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(a[i*8 +: 8]) * int'(b[i*8 +: 8]);
    return 20'(s);
  endfunction

  function automatic logic [15:0] active(input logic [127:0] a, input logic [127:0] b);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (a[i*8 +: 8] != 8'd0) && (b[i*8 +: 8] != 8'd0);
    return r;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++)
      v[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic checkOutput(input string tag);
    vectors++;
    assert (out_Final === mdl_out) else begin
      miscompares++;
      $error("[TB] FAIL %s: out_Final=%0d expected=%0d", tag, out_Final, mdl_out);
    end
  endtask

  task automatic checkValue(input string tag, input logic [19:0] want);
    vectors++;
    assert (out_Final === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: out_Final=%0d expected=%0d", tag, out_Final, want);
    end
  endtask

  task automatic checkAct(input string tag, input logic [15:0] want);
    vectors++;
    assert (dut.act === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: act=%h expected=%h", tag, dut.act, want);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b,
                               input logic r, input string tag);
    Vector_A = a;
    Vector_B = b;
    rst      = r;
    #1;
    checkAct({tag, "_act"}, active(a, b));
    @(posedge clk);
    mdl_out  = r ? 20'd0 : mdl_pipe;
    mdl_pipe = r ? 20'd0 : dot(a, b);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mdl_pipe    = 20'd0;
    mdl_out     = 20'd0;
    for (int i = 0; i < 16; i++) begin
      ones_v[i*8 +: 8] = 8'h01;
      max_v[i*8 +: 8]  = 8'hFF;
      zero_v[i*8 +: 8] = 8'h00;
      twos_v[i*8 +: 8] = 8'h02;
      part_a[i*8 +: 8] = 8'h00;
    end
    part_a[7:0]     = 8'h03;
    part_a[127:120] = 8'h10;
    rst      = 1'b1;
    Vector_A = ones_v;
    Vector_B = ones_v;
    #2;

    applyStimulus(ones_v, ones_v, 1'b1, "reset");
    checkValue("reset_zero", 20'd0);
    applyStimulus(ones_v, ones_v, 1'b0, "first_release");
    checkValue("first_release_zero", 20'd0);
    applyStimulus(max_v, max_v, 1'b0, "stream_ones");
    checkValue("ones_16", 20'd16);
    applyStimulus(part_a, twos_v, 1'b0, "stream_max");
    checkValue("max_fe010", 20'hFE010);
    checkAct("partial_lanes", 16'h8001);
    applyStimulus(max_v, zero_v, 1'b0, "stream_partial");
    checkValue("partial_38", 20'd38);
    checkAct("sparse_none", 16'h0000);
    applyStimulus(max_v, max_v, 1'b0, "sparse");
    checkValue("sparse_zero", 20'd0);

    applyStimulus(max_v, max_v, 1'b0, "max_run1");
    checkValue("max_run1_val", 20'hFE010);
    applyStimulus(max_v, max_v, 1'b1, "mid_reset");
    checkValue("mid_reset_zero", 20'd0);
    applyStimulus(max_v, max_v, 1'b0, "after_reset1");
    checkValue("after_reset1_zero", 20'd0);
    applyStimulus(max_v, max_v, 1'b0, "after_reset2");
    checkValue("after_reset2_val", 20'hFE010);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(rand_vec(), rand_vec(), ($urandom_range(0, 15) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
